pla_seq_eval: RTL

PLA_SEQ_EVAL -- requirements
Module: pla_seq_eval

---
 rtl/pla_pkg.sv | 21 ++
 rtl/pla_cube_match.sv | 14 +
 rtl/pla_seq_eval.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pla_pkg.sv
// Shared types for the sequential PLA evaluator: controller states and the
// cube record held in the product-term store.
package pla_pkg;

  localparam int PLA_NIN  = 7;
  localparam int PLA_NOUT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One product term: care mask, literal polarity and the outputs it feeds.
  typedef struct packed {
    logic [PLA_NIN-1:0]  care;
    logic [PLA_NIN-1:0]  val;
    logic [PLA_NOUT-1:0] omask;
  } cube_t;

endpackage

// File: rtl/pla_cube_match.sv
// Combinational single-cube test: the cube hits when every cared-for input
// equals its literal polarity.
module pla_cube_match #(
  parameter int NIN = 7
) (
  input  logic [NIN-1:0] x,
  input  logic [NIN-1:0] care,
  input  logic [NIN-1:0] val,
  output logic           hit
);

  assign hit = &((x ~^ val) | ~care);

endmodule

// File: rtl/pla_seq_eval.sv
// Sequential PLA evaluator: one product term per SCAN cycle through a single
// shared cube matcher, OR-accumulated per output, then polarity-corrected.
module pla_seq_eval
  import pla_pkg::*;
#(
  parameter int NIN   = PLA_NIN,
  parameter int NOUT  = PLA_NOUT,
  parameter int NTERM = 16,
  localparam int TW   = $clog2(NTERM + 1),
  localparam int AW   = (NTERM > 1) ? $clog2(NTERM) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  output logic            cfg_ready,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [NIN-1:0]  cfg_care,
  input  logic [NIN-1:0]  cfg_val,
  input  logic [NOUT-1:0] cfg_omask,
  input  logic            cfg_nterm_we,
  input  logic [TW-1:0]   cfg_nterm,
  input  logic            cfg_pol_we,
  input  logic [NOUT-1:0] cfg_pol,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NIN-1:0]  in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NOUT-1:0] out_y
);

  state_e          state_q, state_d;
  logic [TW-1:0]   term_q, term_d;
  logic [TW-1:0]   nterm_q, nterm_d;
  logic [NOUT-1:0] pol_q, pol_d;
  logic [NOUT-1:0] acc_q, acc_d;
  logic [NIN-1:0]  x_q, x_d;
  logic [NOUT-1:0] out_y_q, out_y_d;
  logic            out_valid_q, out_valid_d;
  cube_t           cube_q [NTERM];
  cube_t           cube_d [NTERM];
  cube_t           cube_cur_s;
  logic            hit_s;

  assign cube_cur_s = cube_q[term_q[AW-1:0]];

  pla_cube_match #(.NIN(NIN)) u_match (
    .x    (x_q),
    .care (cube_cur_s.care),
    .val  (cube_cur_s.val),
    .hit  (hit_s)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign cfg_ready = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

  // Next-state, config-store and datapath updates.
  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    nterm_d     = nterm_q;
    pol_d       = pol_q;
    acc_d       = acc_q;
    x_d         = x_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    cube_d      = cube_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          cube_d[cfg_addr] = '{care: cfg_care, val: cfg_val, omask: cfg_omask};
        end else begin
          cube_d = cube_q;
        end
        if (cfg_nterm_we) begin
          nterm_d = (cfg_nterm > TW'(NTERM)) ? TW'(NTERM) : cfg_nterm;
        end else begin
          nterm_d = nterm_q;
        end
        if (cfg_pol_we) begin
          pol_d = cfg_pol;
        end else begin
          pol_d = pol_q;
        end
        // The new cube is committed on this edge, so the scan that starts
        // here already sees it.
        if (in_valid) begin
          x_d     = in_x;
          acc_d   = '0;
          term_d  = '0;
          state_d = (nterm_d != '0) ? ST_SCAN : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (hit_s) begin
          acc_d = acc_q | cube_cur_s.omask;
        end else begin
          acc_d = acc_q;
        end
        if ((term_q + TW'(1)) == nterm_q) begin
          state_d = ST_DONE;
        end else begin
          term_d = term_q + TW'(1);
        end
      end
      ST_DONE: begin
        if (!out_valid_q) begin
          out_y_d     = acc_q ^ pol_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      term_q      <= '0;
      nterm_q     <= '0;
      pol_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NTERM; i++) begin
        cube_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      term_q      <= term_d;
      nterm_q     <= nterm_d;
      pol_q       <= pol_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      cube_q      <= cube_d;
    end
  end

endmodule
